// File: rtl/bus_burst_master_if.sv
// Valid/ready data bus between a burst master and the slave it drives.
// The master holds data/valid until the slave raises ready.
interface bus_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/bus_burst_master.sv
// Burst traffic generator: programmable length, inter-beat gap, incrementing or LFSR payload,
// last-beat marking and abort at the next beat boundary.
module bus_burst_master #(
  parameter int          WIDTH     = 32,
  parameter int          MAX_BURST = 16,
  parameter int          GAP       = 0,
  parameter int          MODE      = 0,
  parameter logic [31:0] SEED      = 32'hACE1,
  localparam int         LW        = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LW-1:0]    burst_len,
  input  logic [WIDTH-1:0] start_value,
  input  logic             abort,
  bus_if.master            bus,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [31:0]      beats_sent
);

  localparam int            GW      = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [31:0]   SEED_NZ = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [LW-1:0] MAXL    = LW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, SEND, GAPW, DONE} state_t;

  typedef struct packed {
    logic [LW-1:0] len;
    logic [LW-1:0] idx;
  } burst_t;

  state_t           state, nstate;
  burst_t           cur;
  logic [GW-1:0]    gap_cnt;
  logic             abort_pend, aborted_q;
  logic [31:0]      lfsr, lfsr_nxt;
  logic [WIDTH-1:0] data_q;
  logic [LW-1:0]    len_in;
  logic             accept, final_beat, abt;

  // LFSR word is repeated across wide buses and truncated on narrow ones.
  function automatic logic [WIDTH-1:0] spread(input logic [31:0] l);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = l[i % 32];
    return r;
  endfunction

  assign accept     = (state == SEND) && bus.ready;
  assign final_beat = (cur.idx == cur.len - LW'(1));
  assign abt        = abort || abort_pend;
  assign len_in     = (burst_len > MAXL) ? MAXL : burst_len;
  assign lfsr_nxt   = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};

  assign bus.valid  = (state == SEND);
  assign bus.data   = data_q;
  assign last       = (state == SEND) && final_beat;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign aborted    = (state == DONE) && aborted_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (start) nstate = (len_in == '0) ? DONE : SEND;
      SEND: if (accept) begin
              if (final_beat || abt) nstate = DONE;
              else if (GAP > 0)      nstate = GAPW;
            end
      GAPW: if (abt)                 nstate = DONE;
            else if (gap_cnt == '0)  nstate = SEND;
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur        <= '0;
      gap_cnt    <= '0;
      abort_pend <= 1'b0;
      aborted_q  <= 1'b0;
      lfsr       <= SEED_NZ;
      data_q     <= '0;
      beats_sent <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cur.len    <= len_in;
          cur.idx    <= '0;
          data_q     <= (MODE == 1) ? spread(lfsr) : start_value;
          abort_pend <= 1'b0;
          aborted_q  <= 1'b0;
        end
        SEND: begin
          if (abort) abort_pend <= 1'b1;
          if (accept) begin
            beats_sent <= beats_sent + 32'd1;
            cur.idx    <= cur.idx + LW'(1);
            // An abort that lands on the final beat still counts as a normal finish.
            aborted_q  <= !final_beat && abt;
            gap_cnt    <= GW'((GAP > 0) ? GAP - 1 : 0);
            if (MODE == 1) begin
              lfsr   <= lfsr_nxt;
              data_q <= spread(lfsr_nxt);
            end else begin
              data_q <= data_q + WIDTH'(1);
            end
          end
        end
        GAPW: begin
          if (abt) aborted_q <= 1'b1;
          gap_cnt <= gap_cnt - GW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_burst_master.sv
// Three burst masters (inc/no gap, inc/gap 2, LFSR/gap 1) share stimulus; a transaction-level
// model per instance predicts every beat, last flag, done/aborted pulse and beat count.
module tb_bus_burst_master;

  logic        clk, reset, start, abort, rnd_en;
  logic [4:0]  burst_len;
  logic [31:0] start_value;
  logic [2:0]  rdy;
  wire  [2:0]  vld, lst, bsy, dn, ab;
  wire  [31:0] dat [3];
  wire  [31:0] bs  [3];

  int n_chk = 0, n_fail = 0;

  bus_if #(.WIDTH(32)) b0 ();
  bus_if #(.WIDTH(32)) b1 ();
  bus_if #(.WIDTH(32)) b2 ();

  assign b0.ready = rdy[0];
  assign b1.ready = rdy[1];
  assign b2.ready = rdy[2];
  assign vld = {b2.valid, b1.valid, b0.valid};
  assign dat[0] = b0.data;
  assign dat[1] = b1.data;
  assign dat[2] = b2.data;

  bus_burst_master #(.WIDTH(32), .MAX_BURST(16), .GAP(0), .MODE(0), .SEED(32'hACE1)) u_inc (
    .clk(clk), .reset(reset), .start(start), .burst_len(burst_len), .start_value(start_value),
    .abort(abort), .bus(b0), .last(lst[0]), .busy(bsy[0]), .done(dn[0]), .aborted(ab[0]),
    .beats_sent(bs[0]));

  bus_burst_master #(.WIDTH(32), .MAX_BURST(16), .GAP(2), .MODE(0), .SEED(32'hACE1)) u_gap (
    .clk(clk), .reset(reset), .start(start), .burst_len(burst_len), .start_value(start_value),
    .abort(abort), .bus(b1), .last(lst[1]), .busy(bsy[1]), .done(dn[1]), .aborted(ab[1]),
    .beats_sent(bs[1]));

  bus_burst_master #(.WIDTH(32), .MAX_BURST(16), .GAP(1), .MODE(1), .SEED(32'hACE1)) u_lfsr (
    .clk(clk), .reset(reset), .start(start), .burst_len(burst_len), .start_value(start_value),
    .abort(abort), .bus(b2), .last(lst[2]), .busy(bsy[2]), .done(dn[2]), .aborted(ab[2]),
    .beats_sent(bs[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int gap_of(input int k);
    return (k == 1) ? 2 : (k == 2) ? 1 : 0;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model state (expected) and observations of the DUT bus, per instance.
  logic        m_act [3], m_abreq [3], m_expd [3], m_expab [3], obs_ab [3];
  int          m_idx [3], m_len [3], m_gap [3], n_acc [3], n_done [3];
  logic [31:0] m_sv [3], m_lfsr [3], m_beats [3], first_d [3], last_d [3];
  logic [31:0] lq [$];

  task automatic mon(input int k);
    logic        was_act;
    logic [31:0] exp_d;
    if (reset) begin
      chk($sformatf("rst_valid%0d", k), 32'(vld[k]), 0);
      chk($sformatf("rst_data%0d", k), dat[k], 0);
      chk($sformatf("rst_busy%0d", k), 32'(bsy[k]), 0);
      chk($sformatf("rst_done%0d", k), 32'(dn[k]), 0);
      chk($sformatf("rst_last%0d", k), 32'(lst[k]), 0);
      chk($sformatf("rst_beats%0d", k), bs[k], 0);
      m_act[k] = 0; m_abreq[k] = 0; m_expd[k] = 0; m_expab[k] = 0;
      m_gap[k] = 0; m_beats[k] = 0; m_lfsr[k] = 32'hACE1;
    end else begin
      was_act = m_act[k];
      if (vld[k] && rdy[k]) begin
        if (n_acc[k] == 0) first_d[k] = dat[k];
        last_d[k] = dat[k];
        n_acc[k]++;
        if (k == 2) lq.push_back(dat[k]);
      end
      if (dn[k]) begin
        n_done[k]++;
        obs_ab[k] = ab[k];
      end
      chk($sformatf("beats_sent%0d", k), bs[k], m_beats[k]);
      chk($sformatf("busy%0d", k), 32'(bsy[k]), 32'(m_act[k]));
      if (m_expd[k]) begin
        chk($sformatf("done%0d", k), 32'(dn[k]), 1);
        chk($sformatf("aborted%0d", k), 32'(ab[k]), 32'(m_expab[k]));
        chk($sformatf("valid_in_done%0d", k), 32'(vld[k]), 0);
        m_expd[k] = 0;
        m_act[k]  = 0;
      end else begin
        chk($sformatf("done_idle%0d", k), 32'(dn[k]), 0);
        if (!m_act[k]) begin
          chk($sformatf("valid_idle%0d", k), 32'(vld[k]), 0);
        end else if (m_gap[k] > 0) begin
          chk($sformatf("gap_valid%0d", k), 32'(vld[k]), 0);
          m_gap[k]--;
          if (abort) begin m_expd[k] = 1; m_expab[k] = 1; end
        end else begin
          exp_d = (k == 2) ? m_lfsr[k] : m_sv[k] + 32'(m_idx[k]);
          chk($sformatf("valid%0d", k), 32'(vld[k]), 1);
          chk($sformatf("data%0d", k), dat[k], exp_d);
          chk($sformatf("last%0d", k), 32'(lst[k]), 32'(m_idx[k] == m_len[k] - 1));
          if (abort) m_abreq[k] = 1;
          if (rdy[k]) begin
            m_beats[k]++;
            m_idx[k]++;
            m_lfsr[k] = lfsr_step(m_lfsr[k]);
            if (m_idx[k] == m_len[k])  begin m_expd[k] = 1; m_expab[k] = 0; end
            else if (m_abreq[k])        begin m_expd[k] = 1; m_expab[k] = 1; end
            else                        m_gap[k] = gap_of(k);
          end
        end
      end
      if (start && !was_act) begin
        m_len[k]   = (int'(burst_len) > 16) ? 16 : int'(burst_len);
        m_idx[k]   = 0;
        m_sv[k]    = start_value;
        m_abreq[k] = 0;
        m_gap[k]   = 0;
        m_act[k]   = 1;
        n_acc[k]   = 0;
        if (m_len[k] == 0) begin m_expd[k] = 1; m_expab[k] = 0; end
      end
    end
  endtask

  always @(negedge clk) for (int k = 0; k < 3; k++) mon(k);

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_en) begin
      for (int k = 0; k < 3; k++) rdy[k] = ($urandom_range(0, 3) != 0);
      abort = ($urandom_range(0, 19) == 0);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600; i++) begin
      if (bsy == 3'b000) break;
      tick();
    end
    chk("idle_wait", 32'(bsy), 0);
  endtask

  task automatic run_burst(input logic [4:0] len, input logic [31:0] sv);
    tick();
    start = 1'b1; burst_len = len; start_value = sv;
    tick();
    start = 1'b0;
    wait_idle();
  endtask

  typedef struct {
    logic [4:0]  len;
    logic [31:0] sv;
    int          n;
    logic [31:0] first;
    logic [31:0] lastd;
  } vec_t;

  vec_t        tbl [5];
  int          tot0;
  logic [6:0]  pat1, pat2;
  logic [31:0] lx;

  initial begin
    tbl[0] = '{5'd4,  32'hFFFF_FFFE, 4,  32'hFFFF_FFFE, 32'h0000_0001};
    tbl[1] = '{5'd0,  32'h0000_0123, 0,  32'h0,         32'h0};
    tbl[2] = '{5'd19, 32'h0000_0010, 16, 32'h0000_0010, 32'h0000_001F};
    tbl[3] = '{5'd1,  32'hFFFF_FFFF, 1,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[4] = '{5'd16, 32'h0000_0000, 16, 32'h0000_0000, 32'h0000_000F};

    reset = 1'b1; start = 1'b0; abort = 1'b0; rnd_en = 1'b0;
    burst_len = '0; start_value = '0; rdy = 3'b111; tot0 = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Table of bursts, all ready=1; u_inc results checked against the table.
    foreach (tbl[i]) begin
      run_burst(tbl[i].len, tbl[i].sv);
      tot0 += tbl[i].n;
      chk($sformatf("tbl%0d_beats", i), 32'(n_acc[0]), 32'(tbl[i].n));
      if (tbl[i].n > 0) begin
        chk($sformatf("tbl%0d_first", i), first_d[0], tbl[i].first);
        chk($sformatf("tbl%0d_lastd", i), last_d[0], tbl[i].lastd);
      end
      chk($sformatf("tbl%0d_sent", i), bs[0], 32'(tot0));
    end
    // LFSR payloads continue across bursts from the seed.
    chk("lfsr_count", 32'(lq.size()), 37);
    lx = 32'hACE1;
    foreach (lq[i]) begin
      chk($sformatf("lfsr_seq%0d", i), lq[i], lx);
      lx = lfsr_step(lx);
    end

    // Gap pattern: len=3 with GAP=2 and GAP=1.
    tick();
    start = 1'b1; burst_len = 5'd3; start_value = 32'h100;
    tick();
    start = 1'b0;
    pat1 = '0; pat2 = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      pat1 = {pat1[5:0], vld[1]};
      pat2 = {pat2[5:0], vld[2]};
    end
    chk("gap2_pattern", 32'(pat1), 32'(7'b1001001));
    chk("gap1_pattern", 32'(pat2), 32'(7'b1010100));
    wait_idle();
    chk("gap2_beats", 32'(n_acc[1]), 3);
    tot0 += 3;

    // Stall beat 2 for three cycles.
    tick();
    start = 1'b1; burst_len = 5'd4; start_value = 32'h55;
    tick();
    start = 1'b0;
    tick();
    rdy[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_data", i), dat[0], 32'h56);
      chk($sformatf("stall%0d_valid", i), 32'(vld[0]), 1);
      chk($sformatf("stall%0d_last", i), 32'(lst[0]), 0);
      tick();
    end
    rdy[0] = 1'b1;
    wait_idle();
    tot0 += 4;
    chk("stall_beats", 32'(n_acc[0]), 4);
    chk("stall_lastd", last_d[0], 32'h58);
    chk("stall_sent", bs[0], 32'(tot0));

    // Abort while beat 2 of 8 is stalled.
    tick();
    start = 1'b1; burst_len = 5'd8; start_value = 32'h200;
    tick();
    start = 1'b0;
    tick();
    rdy[0] = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    rdy[0] = 1'b1;
    wait_idle();
    tot0 += 2;
    chk("abort_beats", 32'(n_acc[0]), 2);
    chk("abort_flag", 32'(obs_ab[0]), 1);
    chk("abort_lastd", last_d[0], 32'h201);
    chk("abort_sent", bs[0], 32'(tot0));

    // Reset between edges mid-burst, then two LFSR bursts restart from the seed.
    tick();
    start = 1'b1; burst_len = 5'd8; start_value = 32'h0;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("async_valid%0d", k), 32'(vld[k]), 0);
      chk($sformatf("async_data%0d", k), dat[k], 0);
      chk($sformatf("async_busy%0d", k), 32'(bsy[k]), 0);
    end
    tick();
    tick();
    reset = 1'b0;
    lq.delete();
    run_burst(5'd2, 32'h0);
    run_burst(5'd2, 32'h0);
    chk("rst_lfsr_count", 32'(lq.size()), 4);
    lx = 32'hACE1;
    foreach (lq[i]) begin
      chk($sformatf("rst_lfsr%0d", i), lq[i], lx);
      lx = lfsr_step(lx);
    end
    chk("rst_sent", bs[0], 4);

    // Random traffic: random lengths, payload bases, ready and abort.
    rnd_en = 1'b1;
    for (int i = 0; i < 40; i++)
      run_burst(5'($urandom_range(0, 20)), $urandom);
    rnd_en = 1'b0;
    rdy = 3'b111;
    abort = 1'b0;
    wait_idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
